// File: rtl/blackboxjam_mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blackboxjam_mac_pkg : shared state encoding and result saturation limits |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package blackboxjam_mac_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCALE = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam int                    c_out_w   = 16;
  localparam logic signed [c_out_w-1:0] c_sat_max = 16'sh7FFF;
  localparam logic signed [c_out_w-1:0] c_sat_min = 16'sh8000;

endpackage
`default_nettype wire

// File: rtl/blackboxjam_mac_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blackboxjam_mac_accum_if : product stream, config and result channel     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface blackboxjam_mac_accum_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic [CNT_W-1:0]        cfg_terms;
  logic signed [IN_W-1:0]  cfg_bias;
  logic [4:0]              cfg_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    busy;

  modport master (
    output in_valid, in_data, cfg_terms, cfg_bias, cfg_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  in_valid, in_data, cfg_terms, cfg_bias, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface
`default_nettype wire

// File: rtl/blackboxjam_sat_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blackboxjam_sat_shift : arithmetic right shift then saturate to OUT_W    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module blackboxjam_sat_shift
  import blackboxjam_mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int OUT_W = c_out_w
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic [4:0]              i_shift,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  logic signed [ACC_W-1:0]   w_shifted;
  logic [ACC_W-OUT_W:0]      w_upper;
  logic                      w_in_range;

  assign w_shifted = i_acc >>> i_shift;

  // Fits in OUT_W only when every bit above the result sign matches it.
  assign w_upper    = w_shifted[ACC_W-1:OUT_W-1];
  assign w_in_range = (&w_upper) | ~(|w_upper);

  always_comb begin
    o_data = w_shifted[OUT_W-1:0];
    o_sat  = 1'b0;
    if (!w_in_range) begin
      o_sat  = 1'b1;
      o_data = w_shifted[ACC_W-1] ? c_sat_min : c_sat_max;
    end
  end

endmodule
`default_nettype wire

// File: rtl/blackboxjam_mac_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blackboxjam_mac_accum : bias + N products, shift, saturate, one result   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module blackboxjam_mac_accum
  import blackboxjam_mac_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = c_out_w,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  blackboxjam_mac_accum_if.slave   bus
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_terms;
  logic [CNT_W-1:0]        w_terms_eff;
  logic [4:0]              r_shift;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_data_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [OUT_W-1:0] r_out_data;
  logic signed [OUT_W-1:0] w_sat_data;
  logic                    r_out_sat;
  logic                    w_sat_flag;
  logic                    r_busy;
  logic                    w_accept;
  logic                    w_first;
  logic                    w_last;
  logic                    w_out_hs;

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.busy      = r_busy;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_out_hs = bus.out_valid && bus.out_ready;
  assign w_first  = (r_count == '0);

  // The first term sees the live config; later terms use the latched copy.
  assign w_terms_eff = w_first ? ((bus.cfg_terms == '0) ? CNT_W'(1) : bus.cfg_terms)
                               : r_terms;
  assign w_last      = w_accept && (r_count == w_terms_eff - CNT_W'(1));

  assign w_data_ext = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}},  bus.in_data};
  assign w_bias_ext = {{(ACC_W-IN_W){bus.cfg_bias[IN_W-1]}}, bus.cfg_bias};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_last)            w_state_nxt = ST_SCALE;
      ST_SCALE:                        w_state_nxt = ST_OUT;
      ST_OUT:   if (bus.out_ready)     w_state_nxt = ST_ACCUM;
      default:                         w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_terms    <= '0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_busy  <= 1'b1;
        r_count <= w_last ? '0 : r_count + CNT_W'(1);
        if (w_first) begin
          r_terms <= w_terms_eff;
          r_shift <= bus.cfg_shift;
          r_acc   <= w_bias_ext + w_data_ext;
        end else begin
          r_acc   <= r_acc + w_data_ext;
        end
      end
      if (r_state == ST_SCALE) begin
        r_out_data <= w_sat_data;
        r_out_sat  <= w_sat_flag;
      end
      if (w_out_hs) r_busy <= 1'b0;
    end
  end

  blackboxjam_sat_shift #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_shift (
    .i_acc   (r_acc),
    .i_shift (r_shift),
    .o_data  (w_sat_data),
    .o_sat   (w_sat_flag)
  );

endmodule
`default_nettype wire

// File: tb/tb_blackboxjam_mac_accum.sv
`default_nettype none
// Self-checking bench: directed vectors plus random vectors against a
// floor-division/clamp reference model.
module tb_blackboxjam_mac_accum;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   vals[$];

  always #5 clk = ~clk;

  blackboxjam_mac_accum_if #(.IN_W(24), .OUT_W(16), .CNT_W(16)) bus ();

  blackboxjam_mac_accum #(
    .IN_W(24), .OUT_W(16), .ACC_W(40), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rand24();
    int r;
    r = int'($urandom_range(0, 16777215));
    return (r >= 8388608) ? r - 16777216 : r;
  endfunction

  // Floor division by 2^sh, written independently of any shift operator.
  function automatic longint floor_div_pow2(longint sum, int sh);
    longint d;
    d = 64'sd1;
    for (int k = 0; k < sh; k++) d = d * 2;
    if (sum >= 0) return sum / d;
    return -((-sum + d - 1) / d);
  endfunction

  function automatic longint clamp16(longint s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Feeds vals[] as one vector, then checks latency, result and handshake.
  // bp>0 holds out_ready low for bp OUT cycles while in_valid stays high
  // with hold_val, which the next vector must consume as its first term.
  task automatic run_vec(input int cfg_t, input int cfg_after, input int bias,
                         input int sh, input int bp, input int hold_val,
                         input string tag);
    longint sum, exp_s, exp_d;
    int     n_eff;
    n_eff = (cfg_t == 0) ? 1 : cfg_t;
    sum   = bias;
    for (int i = 0; i < n_eff; i++) sum += vals[i];
    exp_s = floor_div_pow2(sum, sh);
    exp_d = clamp16(exp_s);

    bus.cfg_terms = 16'(cfg_t);
    bus.cfg_bias  = 24'(bias);
    bus.cfg_shift = 5'(sh);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n_eff; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 24'(vals[i]);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      tick();
      if (i == 0) begin
        bus.cfg_terms = 16'(cfg_after);
        bus.cfg_bias  = 24'(rand24());
        bus.cfg_shift = 5'($urandom_range(0, 31));
        chk({tag, "_busy"}, bus.busy, 1);
      end
    end
    if (bp > 0) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 24'(hold_val);
      bus.out_ready = 1'b0;
    end else begin
      bus.in_valid  = 1'b0;
    end
    chk({tag, "_scale_valid"}, bus.out_valid, 0);
    chk({tag, "_scale_ready"}, bus.in_ready, 0);
    tick();
    chk({tag, "_out_valid"}, bus.out_valid, 1);
    for (int k = 0; k < bp; k++) begin
      chk({tag, "_bp_data"},  bus.out_data, exp_d);
      chk({tag, "_bp_valid"}, bus.out_valid, 1);
      chk({tag, "_bp_ready"}, bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    chk({tag, "_data"}, bus.out_data, exp_d);
    chk({tag, "_sat"},  bus.out_sat, (exp_d != exp_s) ? 1 : 0);
    tick();
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_busy_drop"},  bus.busy, 0);
    chk({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    int carry;
    bit has_carry;
    int t, bp, nv;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_terms = '0;
    bus.cfg_bias  = '0;
    bus.cfg_shift = '0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_out_sat",   bus.out_sat, 0);
    chk("rst_busy",      bus.busy, 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready",  bus.in_ready, 1);

    vals = '{1, 2, 3, 4};
    run_vec(4, 4, 0, 0, 0, 0, "sum4");
    vals = '{8388607, 8388607};
    run_vec(2, 2, 0, 0, 0, 0, "satpos");
    vals = '{-8388608, -8388608};
    run_vec(2, 2, 0, 0, 0, 0, "satneg");
    vals = '{-100, -200, -4};
    run_vec(3, 3, -16, 2, 0, 0, "shift2");
    vals = '{-1};
    run_vec(1, 1, 0, 4, 0, 0, "floor");

    vals = '{1000, -3};
    run_vec(2, 2, 100, 1, 5, 77, "bp");
    vals = '{77, 3};
    run_vec(2, 2, 0, 0, 0, 0, "after_bp");

    // Reset in the middle of a vector must leave no residue.
    bus.cfg_terms = 16'd4;
    bus.cfg_bias  = 24'd0;
    bus.cfg_shift = 5'd0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'd1000;
    tick();
    tick();
    bus.in_valid  = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_busy",  bus.busy, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_quiet", bus.out_valid, 0);
    end
    vals = '{5, 5};
    run_vec(2, 2, 0, 0, 0, 0, "rst_recover");

    vals = '{7};
    run_vec(0, 0, 3, 0, 0, 0, "terms0");
    vals = '{10, 20, 30};
    run_vec(3, 1, 0, 0, 0, 0, "cfg_change");

    has_carry = 1'b0;
    carry     = 0;
    nv        = 25;
    for (int v = 0; v < nv; v++) begin
      t = int'($urandom_range(0, 6));
      vals.delete();
      for (int i = 0; i < ((t == 0) ? 1 : t); i++) vals.push_back(rand24());
      if (has_carry) vals[0] = carry;
      bp = (v == nv - 1) ? 0 : int'($urandom_range(0, 3));
      has_carry = (bp > 0);
      carry     = rand24();
      run_vec(t, int'($urandom_range(0, 8)), rand24(),
              int'($urandom_range(0, 31)), bp, carry, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blackboxjam_mac_accum.md
# blackboxjam_mac_accum

Streaming accumulate/requantize stage downstream of the signed 16x24 product multiplier in the BlackBoxJam datapath. Consumes one signed 24-bit product per cycle, sums a run-time number of products onto a bias, rescales with an arithmetic right shift, saturates to 16 bits, and presents one result per vector on a valid/ready output. The result is the neuron pre-activation for the next layer.

## Interface
- IN_W, 24, product width (signed)
- OUT_W, 16, result width (signed)
- ACC_W, 40, accumulator width; never wraps for ≤65535 full-scale terms
- CNT_W, 16, term counter width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; the only reset
- in_valid  in  1  product valid
- in_ready  out  1  block accepts product this cycle
- in_data  in  IN_W  signed product
- cfg_terms  in  CNT_W  products per vector; 0 treated as 1
- cfg_bias  in  IN_W  signed bias, sign-extended to ACC_W
- cfg_shift  in  5  arithmetic right-shift amount 0..31
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed saturated result
- out_sat  out  1  result was clipped
- busy  out  1  vector in progress (≥1 term accepted, result not yet taken)

## Operation
- Accept = in_valid && in_ready.
- States: ACCUM, SCALE, OUT. Reset → ACCUM, count=0, acc=0.
- ACCUM: in_ready=1. On accept with count==0: latch cfg_terms/cfg_bias/cfg_shift, acc ← sext(bias)+sext(in_data). Later accepts: acc ← acc+sext(in_data). count increments per accept.
- Accept when count == latched_terms-1 (including the first term if terms≤1) → SCALE, count ← 0.
- SCALE: in_ready=0. Compute s = acc >>> shift (arithmetic, floor toward −inf). If s > 2^(OUT_W-1)-1: out_data=32767, out_sat=1. If s < −2^(OUT_W-1): out_data=−32768, out_sat=1. Else out_data=s[OUT_W-1:0], out_sat=0. Registers load at end of SCALE → OUT.
- OUT: out_valid=1, in_ready=0. out_data/out_sat held stable until out_ready. On out_valid&&out_ready → ACCUM, out_valid=0 next cycle.
- cfg_* changes after the first term of a vector are ignored until the next vector.
- in_valid without accept (SCALE/OUT): data ignored; upstream holds it.
- No internal overflow check on acc; ACC_W sizing is the guarantee.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, busy=0, state=ACCUM. in_ready is combinational (state==ACCUM), so it reads 1 in the cycle after reset deasserts.
- Reset mid-vector or mid-OUT: partial sum and pending result discarded, no output emitted.
- Latency: last term accepted in cycle t → SCALE in t+1 → out_valid high in t+2.
- Throughput: terms+2 cycles per vector with out_ready=1; each backpressured cycle adds one.
- First term of the next vector can be accepted the cycle after the output handshake.
- busy=1 from the cycle after the first accept until the cycle after the output handshake.

## Structure
- Package blackboxjam_mac_pkg holds the state enum (ACCUM/SCALE/OUT) and the OUT_W saturation limits (max/min) as constants.
- Sub-module blackboxjam_sat_shift: combinational ACC_W→OUT_W arithmetic shift and saturate, producing data and sat flag. Instantiated once, ahead of the output register.
- Top holds the FSM, counter, config latches, accumulator and output registers.

## Test plan
- terms=4, bias=0, shift=0, products 1,2,3,4 back-to-back, out_ready=1 → out_data=10, out_sat=0, out_valid exactly 2 cycles after the 4th accept, single cycle.
- terms=2, bias=0, shift=0, products 8388607 twice → out_data=32767, out_sat=1. Mirror with −8388608 twice → −32768, out_sat=1.
- terms=3, bias=−16, shift=2, products −100,−200,−4 → sum −320 → out_data=−80, out_sat=0. Single term −1, shift=4 → −1 (floor).
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → out_data stable, in_ready=0, no term consumed. After the handshake, the next vector's first term is accepted the following cycle.
- Reset asserted after 2 of 4 terms → out_valid stays 0. Then terms=2, products 5,5, bias 0 → out_data=10, no residue.
- cfg_terms=0, bias=3, product 7 → out_data=10. cfg_terms changed mid-vector from 3 to 1 → vector still uses 3 terms.
